// File: rtl/grf_write_arb_if.sv
// Bundle of the GRF write arbiter's pipeline, multi-cycle, stall-query and GRF-port signals.
// The master side drives requests; the slave side is the arbiter.
interface grf_write_arb_if;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        m_issue;
  logic [4:0]  m_issue_addr;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_wd;
  logic [31:0] m_pc;
  logic        m_ready;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_busy1;
  logic        q_busy2;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [1:0]  fifo_cnt;

  modport master (
    output p_we, p_addr, p_wd, p_pc, m_issue, m_issue_addr,
    output m_valid, m_addr, m_wd, m_pc, q_a1, q_a2,
    input  m_ready, q_busy1, q_busy2, grf_a3, grf_wd, grf_we, grf_pc, fifo_cnt
  );

  modport slave (
    input  p_we, p_addr, p_wd, p_pc, m_issue, m_issue_addr,
    input  m_valid, m_addr, m_wd, m_pc, q_a1, q_a2,
    output m_ready, q_busy1, q_busy2, grf_a3, grf_wd, grf_we, grf_pc, fifo_cnt
  );
endinterface

// File: rtl/grf_write_arb.sv
// Single-port GRF write arbiter: pipeline writeback has priority over a 2-entry multi-cycle
// result FIFO; WAW overwrites by the pipeline kill stale buffered results.
module grf_write_arb #(
  parameter int unsigned DEPTH = 2
) (
  input logic            clk,
  input logic            reset,
  grf_write_arb_if.slave bus
);

  logic [4:0]       ent_addr_q [DEPTH];
  logic [31:0]      ent_wd_q   [DEPTH];
  logic [31:0]      ent_pc_q   [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [DEPTH-1:0] ent_kill_q;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       cnt_q;
  logic [31:0]      pend_q;
  logic [31:0]      pend_d;

  logic             ready;
  logic             p_sel;
  logic             pop;
  logic             push;
  logic             push_kill;
  logic [DEPTH-1:0] kill_hit;
  logic [31:0]      pend_clr;
  logic [31:0]      pend_set;

  always_comb begin
    ready     = reset && ({30'd0, cnt_q} < DEPTH);
    p_sel     = reset && bus.p_we && (bus.p_addr != 5'd0);
    pop       = reset && !p_sel && (cnt_q != 2'd0);
    push      = bus.m_valid && ready;
    push_kill = p_sel && (bus.m_addr == bus.p_addr);
    for (int i = 0; i < int'(DEPTH); i++) begin
      kill_hit[i] = p_sel && ent_vld_q[i] && (ent_addr_q[i] == bus.p_addr);
    end

    pend_clr = '0;
    pend_set = '0;
    if (pop) pend_clr[ent_addr_q[rd_ptr_q]] = 1'b1;
    if ((|kill_hit) || (push && push_kill)) pend_clr[bus.p_addr] = 1'b1;
    if (reset && bus.m_issue && (bus.m_issue_addr != 5'd0)) pend_set[bus.m_issue_addr] = 1'b1;
    // Set wins over a same-edge clear.
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_comb begin
    bus.grf_we = 1'b0;
    bus.grf_a3 = 5'd0;
    bus.grf_wd = 32'd0;
    bus.grf_pc = 32'd0;
    if (p_sel) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = bus.p_addr;
      bus.grf_wd = bus.p_wd;
      bus.grf_pc = bus.p_pc;
    end else if (pop && !ent_kill_q[rd_ptr_q]) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = ent_addr_q[rd_ptr_q];
      bus.grf_wd = ent_wd_q[rd_ptr_q];
      bus.grf_pc = ent_pc_q[rd_ptr_q];
    end
  end

  always_comb begin
    bus.m_ready  = ready;
    bus.fifo_cnt = cnt_q;
    bus.q_busy1  = (bus.q_a1 != 5'd0) && pend_q[bus.q_a1];
    bus.q_busy2  = (bus.q_a2 != 5'd0) && pend_q[bus.q_a2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_vld_q  <= '0;
      ent_kill_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      pend_q     <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (kill_hit[i]) ent_kill_q[i] <= 1'b1;
      end
      // The popped slot is never kill_hit (P not selected) and the pushed slot is empty.
      if (pop) begin
        ent_vld_q[rd_ptr_q]  <= 1'b0;
        ent_kill_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= ~rd_ptr_q;
      end
      if (push) begin
        ent_addr_q[wr_ptr_q] <= bus.m_addr;
        ent_wd_q[wr_ptr_q]   <= bus.m_wd;
        ent_pc_q[wr_ptr_q]   <= bus.m_pc;
        ent_vld_q[wr_ptr_q]  <= 1'b1;
        ent_kill_q[wr_ptr_q] <= (bus.m_addr == 5'd0) || push_kill;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_grf_write_arb.sv
// Directed bench for grf_write_arb: a queue-based model checked every cycle, plus literal
// expectations for each scenario.
module tb_grf_write_arb;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  grf_write_arb_if bus ();

  grf_write_arb #(.DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] pc;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  bit          mpend[32];
  logic [31:0] mgrf[32];
  logic [4:0]  wlog[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle model compare and update; inputs are stable from posedge+1 to the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit p_ok, e_we, e_rdy, push;
        logic [4:0] e_a3;
        logic [31:0] e_wd, e_pc;
        int sz;
        sz    = mq.size();
        p_ok  = reset && bus.p_we && (bus.p_addr != 5'd0);
        e_we  = 1'b0;
        e_a3  = '0;
        e_wd  = '0;
        e_pc  = '0;
        if (p_ok) begin
          e_we = 1'b1; e_a3 = bus.p_addr; e_wd = bus.p_wd; e_pc = bus.p_pc;
        end else if (reset && sz > 0) begin
          e_we = !mq[0].kill; e_a3 = mq[0].addr; e_wd = mq[0].wd; e_pc = mq[0].pc;
        end
        e_rdy = reset && (sz < 2);
        cmp("grf_we", {31'd0, bus.grf_we}, {31'd0, e_we});
        if (e_we) begin
          cmp("grf_a3", {27'd0, bus.grf_a3}, {27'd0, e_a3});
          cmp("grf_wd", bus.grf_wd, e_wd);
          cmp("grf_pc", bus.grf_pc, e_pc);
        end
        cmp("m_ready", {31'd0, bus.m_ready}, {31'd0, e_rdy});
        cmp("fifo_cnt", {30'd0, bus.fifo_cnt}, 32'(sz));
        cmp("q_busy1", {31'd0, bus.q_busy1}, {31'd0, (bus.q_a1 != 0) && mpend[bus.q_a1]});
        cmp("q_busy2", {31'd0, bus.q_busy2}, {31'd0, (bus.q_a2 != 0) && mpend[bus.q_a2]});
        if (bus.grf_we === 1'b1) wlog.push_back(bus.grf_a3);
        if (e_we) mgrf[e_a3] = e_wd;

        if (!reset) begin
          mq.delete();
          for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        end else begin
          push = bus.m_valid && e_rdy;
          if (!p_ok && sz > 0) begin
            mpend[mq[0].addr] = 1'b0;
            void'(mq.pop_front());
          end
          if (p_ok) begin
            foreach (mq[i]) begin
              if (mq[i].addr == bus.p_addr) begin
                mq[i].kill = 1'b1;
                mpend[bus.p_addr] = 1'b0;
              end
            end
          end
          if (push) begin
            ent_t e;
            e.addr = bus.m_addr; e.wd = bus.m_wd; e.pc = bus.m_pc;
            e.kill = (bus.m_addr == 0) || (p_ok && bus.m_addr == bus.p_addr);
            if (p_ok && bus.m_addr == bus.p_addr) mpend[bus.p_addr] = 1'b0;
            mq.push_back(e);
          end
          if (bus.m_issue && bus.m_issue_addr != 0) mpend[bus.m_issue_addr] = 1'b1;
        end
      end
    end
  end

  task automatic idle();
    bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wd = '0; bus.p_pc = '0;
    bus.m_issue = 1'b0; bus.m_issue_addr = '0;
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wd = '0; bus.m_pc = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic pw(logic [4:0] a, logic [31:0] d);
    bus.p_we = 1'b1; bus.p_addr = a; bus.p_wd = d; bus.p_pc = 32'h4000_0000 | d;
  endtask

  task automatic mv(logic [4:0] a, logic [31:0] d);
    bus.m_valid = 1'b1; bus.m_addr = a; bus.m_wd = d; bus.m_pc = 32'h3000 + {27'd0, a};
  endtask

  task automatic iss(logic [4:0] a);
    bus.m_issue = 1'b1; bus.m_issue_addr = a;
  endtask

  function automatic int count_writes(logic [4:0] a);
    int n = 0;
    foreach (wlog[i]) if (wlog[i] == a) n++;
    return n;
  endfunction

  initial begin
    idle();
    bus.q_a1 = 5'd5; bus.q_a2 = 5'd0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step();
    reset = 1'b1;
    @(negedge clk);
    cmp("rst_we", {31'd0, bus.grf_we}, 32'd0);
    cmp("rst_ready", {31'd0, bus.m_ready}, 32'd1);
    cmp("rst_cnt", {30'd0, bus.fifo_cnt}, 32'd0);
    cmp("rst_busy", {31'd0, bus.q_busy1}, 32'd0);

    // Issue $5, result one cycle later, written the following cycle.
    step(); iss(5'd5);
    step(); mv(5'd5, 32'h1234);
    @(negedge clk); cmp("s1_busy_pre", {31'd0, bus.q_busy1}, 32'd1);
    step();
    @(negedge clk);
    cmp("s1_we", {31'd0, bus.grf_we}, 32'd1);
    cmp("s1_a3", {27'd0, bus.grf_a3}, 32'd5);
    cmp("s1_wd", bus.grf_wd, 32'h1234);
    cmp("s1_busy_hold", {31'd0, bus.q_busy1}, 32'd1);
    step();
    @(negedge clk); cmp("s1_busy_post", {31'd0, bus.q_busy1}, 32'd0);

    // Two M results held off by three P writes to $3.
    wlog.delete();
    bus.q_a1 = 5'd6; bus.q_a2 = 5'd7;
    step(); iss(5'd6);
    step(); iss(5'd7);
    step(); pw(5'd3, 32'h31); mv(5'd6, 32'h66);
    step(); pw(5'd3, 32'h32); mv(5'd7, 32'h77);
    step(); pw(5'd3, 32'h33);
    @(negedge clk);
    cmp("s2_full_ready", {31'd0, bus.m_ready}, 32'd0);
    cmp("s2_full_cnt", {30'd0, bus.fifo_cnt}, 32'd2);
    step(); step(); step();
    @(negedge clk);
    cmp("s2_drained", {30'd0, bus.fifo_cnt}, 32'd0);
    cmp("s2_nwrites", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      cmp("s2_w0", {27'd0, wlog[0]}, 32'd3);
      cmp("s2_w2", {27'd0, wlog[2]}, 32'd3);
      cmp("s2_w3", {27'd0, wlog[3]}, 32'd6);
      cmp("s2_w4", {27'd0, wlog[4]}, 32'd7);
    end

    // Buffered $8 killed by a P write to $8.
    wlog.delete();
    bus.q_a1 = 5'd8; bus.q_a2 = 5'd9;
    step(); iss(5'd8);
    step(); mv(5'd8, 32'hBBBB);
    step(); pw(5'd8, 32'hAAAA);
    @(negedge clk); cmp("s3_busy_pre", {31'd0, bus.q_busy1}, 32'd1);
    step();
    @(negedge clk);
    cmp("s3_killed_we", {31'd0, bus.grf_we}, 32'd0);
    cmp("s3_killed_cnt", {30'd0, bus.fifo_cnt}, 32'd1);
    cmp("s3_busy_post", {31'd0, bus.q_busy1}, 32'd0);
    step();
    @(negedge clk);
    cmp("s3_grf8", mgrf[8], 32'hAAAA);
    cmp("s3_writes8", 32'(count_writes(5'd8)), 32'd1);

    // P and an M result for $9 in the same cycle.
    wlog.delete();
    step(); iss(5'd9);
    step(); pw(5'd9, 32'h9999); mv(5'd9, 32'h1111);
    step();
    @(negedge clk);
    cmp("s4_busy", {31'd0, bus.q_busy2}, 32'd0);
    cmp("s4_we", {31'd0, bus.grf_we}, 32'd0);
    step(); step();
    @(negedge clk);
    cmp("s4_writes9", 32'(count_writes(5'd9)), 32'd1);
    cmp("s4_grf9", mgrf[9], 32'h9999);

    // Register 0 from both sources.
    wlog.delete();
    step(); mv(5'd0, 32'hDEAD); pw(5'd0, 32'h1);
    @(negedge clk); cmp("s5_we_p0", {31'd0, bus.grf_we}, 32'd0);
    step(); pw(5'd0, 32'h2);
    @(negedge clk);
    cmp("s5_cnt1", {30'd0, bus.fifo_cnt}, 32'd1);
    cmp("s5_we_head", {31'd0, bus.grf_we}, 32'd0);
    step();
    @(negedge clk);
    cmp("s5_cnt0", {30'd0, bus.fifo_cnt}, 32'd0);
    cmp("s5_writes0", 32'(count_writes(5'd0)), 32'd0);

    // Reset with two buffered entries.
    wlog.delete();
    bus.q_a1 = 5'd10; bus.q_a2 = 5'd11;
    step(); iss(5'd10);
    step(); iss(5'd11);
    step(); pw(5'd2, 32'h21); mv(5'd10, 32'hA0);
    step(); pw(5'd2, 32'h22); mv(5'd11, 32'hB0);
    step(); reset = 1'b0; pw(5'd2, 32'h23); iss(5'd12);
    @(negedge clk);
    cmp("s6_rst_we", {31'd0, bus.grf_we}, 32'd0);
    cmp("s6_rst_ready", {31'd0, bus.m_ready}, 32'd0);
    step(); reset = 1'b1;
    @(negedge clk);
    cmp("s6_cnt", {30'd0, bus.fifo_cnt}, 32'd0);
    cmp("s6_busy10", {31'd0, bus.q_busy1}, 32'd0);
    cmp("s6_busy11", {31'd0, bus.q_busy2}, 32'd0);
    cmp("s6_ready", {31'd0, bus.m_ready}, 32'd1);
    step(); step(); step();
    @(negedge clk);
    cmp("s6_writes10", 32'(count_writes(5'd10)), 32'd0);
    cmp("s6_writes11", 32'(count_writes(5'd11)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
